// File: rtl/dff_shift_sequencer.sv
// Parallel-in/serial-out sequencer: captures a word on start and shifts it out
// one bit per clock in the captured direction, reporting busy, bit index and done.
module dff_shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CW    = 2
) (
   input  logic             C,
   input  logic             RE,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             dir,
   input  logic             en,
   output logic             sout,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE_IDX  = CW'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dir_q, dir_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // State and datapath registers with synchronous reset
   always_ff @(posedge C) begin
      if (RE) begin
         state_q <= ST_IDLE;
         shreg_q <= {WIDTH{1'b0}};
         dir_q   <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: capture in IDLE, shift toward the output end in SHIFT
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d = din;
               dir_d   = dir;
               cnt_d   = {CW{1'b0}};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (en) begin
               if (cnt_q == LAST_IDX) begin
                  shreg_d = {WIDTH{1'b0}};
                  cnt_d   = {CW{1'b0}};
                  state_d = ST_DONE;
               end else begin
                  shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
                  cnt_d   = cnt_q + ONE_IDX;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            cnt_d   = {CW{1'b0}};
            state_d = ST_IDLE;
         end
         default: begin
            shreg_d = {WIDTH{1'b0}};
            dir_d   = 1'b0;
            cnt_d   = {CW{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      sout = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      cnt  = {CW{1'b0}};
      case (state_q)
         ST_SHIFT: begin
            busy = 1'b1;
            sout = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
            cnt  = cnt_q;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         ST_IDLE: begin
            busy = 1'b0;
         end
         default: begin
            done = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dff_shift_sequencer.sv
// Bench for dff_shift_sequencer (WIDTH=4): directed scenarios plus a random
// phase, all checked cycle by cycle against a transfer-level reference model.
module tb_dff_shift_sequencer;

   logic       C = 1'b0;
   logic       RE = 1'b1;
   logic       start = 1'b0;
   logic [3:0] din = 4'd0;
   logic       dir = 1'b0;
   logic       en = 1'b0;
   logic       sout;
   logic       busy;
   logic       done;
   logic [1:0] cnt;

   int total = 0;
   int bad = 0;

   // reference model: phase 0=idle, 1=sending bit m_idx of m_word, 2=done pulse
   int         m_phase = 0;
   int         m_idx = 0;
   logic [3:0] m_word = 4'd0;
   logic       m_dir = 1'b0;

   // observation trackers for directed scenarios
   logic [7:0] seq_bits;
   int         busy_seen;
   int         done_seen;
   int         done_at;
   int         obs_n;

   dff_shift_sequencer #(.WIDTH(4), .CW(2)) dut (
      .C(C), .RE(RE), .start(start), .din(din), .dir(dir), .en(en),
      .sout(sout), .busy(busy), .done(done), .cnt(cnt)
   );

   always #5 C = ~C;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      seq_bits  = 8'd0;
      busy_seen = 0;
      done_seen = 0;
      done_at   = 0;
      obs_n     = 0;
   endtask

   task automatic cyc(input logic re, input logic st, input logic [3:0] d,
                      input logic dr, input logic e);
      int exp_sout;
      RE = re; start = st; din = d; dir = dr; en = e;
      @(posedge C);
      if (re) begin
         m_phase = 0;
         m_idx   = 0;
      end else if (m_phase == 0) begin
         if (st) begin
            m_word  = d;
            m_dir   = dr;
            m_idx   = 0;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (e) begin
            if (m_idx == 3) m_phase = 2;
            else            m_idx++;
         end
      end else begin
         m_phase = 0;
      end
      #1;
      exp_sout = (m_phase == 1) ? int'(m_word[m_dir ? m_idx : 3 - m_idx]) : 0;
      chk("sout", int'(sout), exp_sout);
      chk("busy", int'(busy), (m_phase == 1) ? 1 : 0);
      chk("done", int'(done), (m_phase == 2) ? 1 : 0);
      chk("cnt",  int'(cnt),  (m_phase == 1) ? m_idx : 0);
      obs_n++;
      if (busy) begin
         seq_bits = {seq_bits[6:0], sout};
         busy_seen++;
      end
      if (done) begin
         done_seen++;
         if (done_at == 0) done_at = obs_n;
      end
   endtask

   initial begin
      // 1: reset with random start/din
      cyc(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      cyc(1'b1, 1'b1, 4'($urandom), 1'($urandom), 1'b1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt", int'(cnt), 0);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

      // 2: MSB first
      clear_obs();
      cyc(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
      repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t2_bits", int'(seq_bits[3:0]), 4'b1011);
      chk("t2_busy_len", busy_seen, 4);
      chk("t2_done_cnt", done_seen, 1);
      chk("t2_done_at", done_at, 5);
      chk("t2_idle", int'(busy | done), 0);

      // 3: LSB first
      clear_obs();
      cyc(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
      repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t3_bits", int'(seq_bits[3:0]), 4'b1101);
      chk("t3_done_at", done_at, 5);
      chk("t3_done_cnt", done_seen, 1);

      // 4: en low for two cycles at cnt=1
      clear_obs();
      cyc(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("t4_hold_cnt", int'(cnt), 1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("t4_hold_sout", int'(sout), 0);
      repeat (4) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t4_bits", int'(seq_bits[5:0]), 6'b100011);
      chk("t4_busy_len", busy_seen, 6);
      chk("t4_done_cnt", done_seen, 1);

      // 5: start during SHIFT at cnt=2 is ignored
      clear_obs();
      cyc(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5_cnt2", int'(cnt), 2);
      cyc(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5_bits", int'(seq_bits[3:0]), 4'b1011);
      chk("t5_busy_len", busy_seen, 4);
      chk("t5_done_cnt", done_seen, 1);

      // 6: reset at cnt=2 aborts without done, then a fresh transfer
      clear_obs();
      cyc(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t6_abort_busy", int'(busy), 0);
      chk("t6_abort_cnt", int'(cnt), 0);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t6_no_done", done_seen, 0);
      clear_obs();
      cyc(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
      repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t6_bits", int'(seq_bits[3:0]), 4'b0110);
      chk("t6_done_cnt", done_seen, 1);

      // random phase against the model
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(31) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(2) == 0) ? 1'b1 : 1'b0,
             4'($urandom), 1'($urandom),
             ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
